pp_gen_pipe: RTL

//  Parametrised, registered partial-product generator at the front of the Dadda

---
 rtl/dadda_pkg.sv | 40 ++++
 rtl/pp_skid_buf.sv | 64 ++++++
 rtl/pp_gen_pipe.sv | 95 +++++++++
 3 files changed

// File: rtl/dadda_pkg.sv
// dadda_pkg
//   Shared definitions for the front end of the Dadda multiplier.
//   - DEF_WA / DEF_WB : default operand widths used across the multiplier.
//   - PP_W / CORR_W   : partial-product and correction widths for those defaults.
//   - pp_payload_t    : the payload handed to the reduction tree, for the defaults.
//   - pp_w / corr_w   : the same widths for any WA/WB. Modules use these because
//                       a package cannot depend on module parameters.
//   - bw_corr         : modified Baugh-Wooley correction constant for a WA x WB product.
package dadda_pkg;

  localparam int DEF_WA = 8;
  localparam int DEF_WB = 8;
  localparam int PP_W   = DEF_WA * DEF_WB;
  localparam int CORR_W = DEF_WA + DEF_WB;

  typedef struct packed {
    logic [PP_W-1:0]   pp;
    logic [CORR_W-1:0] corr;
    logic              sgn;
  } pp_payload_t;

  function automatic int pp_w(input int wa, input int wb);
    return wa * wb;
  endfunction

  function automatic int corr_w(input int wa, input int wb);
    return wa + wb;
  endfunction

  // 2^(wa-1) + 2^(wb-1) + 2^(wa+wb-1), reduced mod 2^(wa+wb).
  // When wa == wb the two low terms add up to a single bit at position wa.
  function automatic logic [63:0] bw_corr(input int wa, input int wb);
    logic [63:0] v;
    v = (64'd1 << (wa - 1)) + (64'd1 << (wb - 1)) + (64'd1 << (wa + wb - 1));
    if (wa + wb < 64)
      v = v & ((64'd1 << (wa + wb)) - 64'd1);
    return v;
  endfunction

endpackage

// File: rtl/pp_skid_buf.sv
// pp_skid_buf
//   Generic 2-entry valid/ready buffer with a fully registered in_ready.
//   An output register and one skid entry hold the data. in_ready is simply
//   "skid entry empty". So a word that arrives while the output is stalled is
//   parked in the skid entry, and in_ready drops one cycle later.
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready is a flop)
//   in_data [W]         upstream payload
//   out_valid/out_ready downstream handshake
//   out_data [W]        downstream payload (held stable while stalled)
module pp_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] out_data_reg;
  logic         out_valid_reg;
  logic [W-1:0] skid_data_reg;
  logic         skid_valid_reg;
  logic         accept;

  assign accept = in_valid && !skid_valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      skid_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
    end else if (skid_valid_reg) begin
      // Skid full implies the output is full and in_ready is low.
      // On drain the parked word moves up, so out_valid stays high.
      if (out_ready) begin
        out_data_reg   <= skid_data_reg;
        skid_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_reg || out_ready) begin
        // The output slot is empty or being emptied this edge, so there is no bubble.
        out_data_reg  <= in_data;
        out_valid_reg <= 1'b1;
      end else begin
        skid_data_reg  <= in_data;
        skid_valid_reg <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign in_ready  = !skid_valid_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

endmodule

// File: rtl/pp_gen_pipe.sv
// pp_gen_pipe
//   Registered partial-product generator feeding the Dadda reduction tree.
//   Each accepted A x B pair produces WB rows of WA bits plus a correction
//   vector. Summing row_i << i with corr, mod 2^(WA+WB), gives the product.
//   signed_mode selects modified Baugh-Wooley: sign-weighted bits are inverted
//   and a constant is added. Latency is 1 cycle, and a 2-entry skid buffer
//   gives a registered in_ready.
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   in_valid/in_ready      operand handshake
//   a [WA], b [WB]         multiplicand, multiplier
//   signed_mode            1 = two's complement operands
//   out_valid/out_ready    result handshake
//   pp [WA*WB]             row i = pp[i*WA +: WA], weight 2^i
//   corr [WA+WB]           constant addend for the tree
//   out_signed             signed_mode of the transaction being presented
module pp_gen_pipe
  import dadda_pkg::*;
#(
  parameter int WA = 8,
  parameter int WB = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WA-1:0]      a,
  input  logic [WB-1:0]      b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WA*WB-1:0]   pp,
  output logic [WA+WB-1:0]   corr,
  output logic               out_signed
);

  localparam int PP_BITS   = pp_w(WA, WB);
  localparam int CORR_BITS = corr_w(WA, WB);
  localparam logic [CORR_BITS-1:0] CORR_SIGNED = CORR_BITS'(bw_corr(WA, WB));

  typedef struct packed {
    logic [PP_BITS-1:0]   pp;
    logic [CORR_BITS-1:0] corr;
    logic                 sgn;
  } payload_t;

  localparam int PAY_W = $bits(payload_t);

  logic [PP_BITS-1:0] pp_comb;
  payload_t           in_pay;
  payload_t           out_pay;
  logic [PAY_W-1:0]   out_pay_bits;

  // Baugh-Wooley inverts the partial products that carry exactly one sign bit.
  // These are the MSB column of rows 0..WB-2 and the low columns of the last row.
  // The sign x sign term keeps its positive weight.
  genvar gi, gj;
  generate
    for (gi = 0; gi < WB; gi++) begin : g_row
      for (gj = 0; gj < WA; gj++) begin : g_col
        localparam bit INV = ((gi < WB - 1) && (gj == WA - 1)) ||
                             ((gi == WB - 1) && (gj < WA - 1));
        if (INV) begin : g_inv
          assign pp_comb[gi*WA + gj] = (a[gj] & b[gi]) ^ signed_mode;
        end else begin : g_pass
          assign pp_comb[gi*WA + gj] = a[gj] & b[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    in_pay      = '0;
    in_pay.pp   = pp_comb;
    in_pay.corr = signed_mode ? CORR_SIGNED : '0;
    in_pay.sgn  = signed_mode;
  end

  pp_skid_buf #(.W(PAY_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pay),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pay_bits)
  );

  assign out_pay    = payload_t'(out_pay_bits);
  assign pp         = out_pay.pp;
  assign corr       = out_pay.corr;
  assign out_signed = out_pay.sgn;

endmodule
